ccff_loader: RTL and testbench
==============================

# ccff_loader

Configuration-chain programmer that drives the `ccff_head` input of the first tile's configuration flip-flop chain and samples the `ccff_tail` output of the last tile. It accepts the bitstream as a stream of words over a valid/ready interface and serializes it onto the chain. It streams the bits emerging from the chain tail back out as readback words, so loading the same bitstream twice returns the first copy for verification. It sits between the host/SPI bitstream source and the fabric's `prog_clk` domain, and its shift enable gates the fabric's programming clock.

## Interface
- `CHAIN_LEN`, default 64: total configuration bits in the chain, ≥1.
- `WORD_W`, default 8: bitstream and readback word width, ≥1.
- `prog_clk`  in  1  sole clock, the programming clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`.
- `in_valid`  in  1  bitstream word valid.
- `in_data`  in  WORD_W  bitstream word, LSB shifted first.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `out_valid`  out  1  readback word valid.
- `out_data`  out  WORD_W  readback word, LSB = first bit out of the tail.
- `out_ready`  in  1  consumer accepts readback word.
- `ccff_head`  out  1  serial data into the chain.
- `ccff_shift_en`  out  1  enable for the external clock gate feeding the fabric's `prog_clk`.
- `ccff_tail`  in  1  serial data from the chain end.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when all CHAIN_LEN bits are shifted and the last readback word is accepted.

## Operation
- Word count N = ceil(CHAIN_LEN/WORD_W). In the last word, only the low CHAIN_LEN − (N−1)·WORD_W bits are shifted. Its remaining bits are ignored, and the matching readback bits are zero.
- FSM states: IDLE, FETCH, SHIFT, EMIT, DONE.
- IDLE → FETCH on `start`. `busy` is 1 in every state except IDLE.
- FETCH:
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, load the shift register and go to SHIFT.
- SHIFT:
  - Each cycle, drive `ccff_head` = shift_reg[0] and `ccff_shift_en` = 1.
  - Capture `ccff_tail` into the readback register at the bit position matching the bit shifted.
  - After WORD_W bits, or when the global bit counter reaches CHAIN_LEN, go to EMIT.
- EMIT:
  - `out_valid` = 1 and `ccff_shift_en` = 0.
  - On `out_ready`, go to FETCH if bits remain, else DONE.
- DONE: pulse `done` for one cycle, then go to IDLE.
- The global bit counter is $clog2(CHAIN_LEN+1) bits wide. It clears on `start` and never wraps.
- `start` while busy has no effect.
- `in_valid` outside FETCH is not accepted.
- Stalls in FETCH or EMIT hold `ccff_shift_en` = 0, so chain contents are frozen.
- Reset mid-load returns to IDLE and clears all counters. Partial chain contents are left as-is, and `done` is not pulsed.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0.
- All outputs are registered except `in_ready`, which is decoded from the state.
- `ccff_head` and `ccff_shift_en` change together on the same edge. The fabric captures `ccff_head` at the next `prog_clk` edge. The loader samples `ccff_tail` at that same edge, before the chain shifts.
- Latency:
  - `start` to the first `ccff_shift_en` is 2 cycles, given `in_valid` already high.
  - A full word costs 1 (FETCH) + WORD_W (SHIFT) + 1 (EMIT) cycles with no stalls.
  - The last `ccff_shift_en` to `done` is 2 cycles with `out_ready` high.
- A total load with no stalls takes CHAIN_LEN + 2N + 2 cycles after `start`.

## Structure
- Shared package `ccff_pkg` holds the FSM state enum (`ccff_state_t`) and the default CHAIN_LEN/WORD_W constants used by the fabric top.
- One sub-module, `ccff_serdes`: a WORD_W shift-out register with a parallel load, paired with a WORD_W shift-in capture register. The FSM and counters live in `ccff_loader`.

## Test plan
- Behavioral chain model of CHAIN_LEN=64, preset all-zero, with WORD_W=8. Load 0x01..0x08 → 64 `ccff_shift_en` cycles, all readback words 0x00, `done` once. Chain contents equal the bitstream in LSB-first order.
- Second load of 0xFF×8 into the same chain → readback equals 0x01..0x08 in order, and the chain holds all ones.
- CHAIN_LEN=20, WORD_W=8, load 0xAA,0xBB,0xCC → exactly 20 shifts. The third readback word has bits [7:4]=0, and only 0x?C's low nibble enters the chain.
- Random `in_valid`/`out_ready` backpressure → `ccff_shift_en` stays 0 in every stall cycle, and the final chain contents and readback match the no-stall run.
- Assert `reset` low after 30 shifts → all outputs return to their reset values asynchronously, and no `done` pulse occurs. A subsequent `start` performs a full 64-bit load.
- `start` pulsed during SHIFT → ignored: the bit count stays 64 and only one `done` pulse occurs.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and fabric defaults.
// Pure declarations; no timing or flow-control behaviour of its own.
package ccff_pkg;

  localparam int CCFF_CHAIN_LEN = 64;
  localparam int CCFF_WORD_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_EMIT,
    ST_DONE
  } ccff_state_t;

  // Index width that stays legal for a single-bit word.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Host-side bitstream/readback handshakes plus the serial chain pins of the loader.
// master = bitstream source, readback sink and chain model; slave = ccff_loader.
interface ccff_loader_if import ccff_pkg::*; #(
  parameter int WORD_W = CCFF_WORD_W
) ();

  logic              start;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, in_data, out_ready, ccff_tail,
    input  in_ready, out_valid, out_data, ccff_head, ccff_shift_en, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready, ccff_tail,
    output in_ready, out_valid, out_data, ccff_head, ccff_shift_en, busy, done
  );

endinterface

// File: rtl/ccff_serdes.sv
// Word shift-out register with parallel load, paired with an indexed shift-in capture register.
// Single-cycle: load or shift takes effect on the next prog_clk edge; no flow control of its own.
module ccff_serdes #(
  parameter int WORD_W = 8,
  parameter int IW     = 3
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_dat_i,
  input  logic              shift_i,
  input  logic              tail_i,
  input  logic [IW-1:0]     cap_idx_i,
  output logic              head_o,
  output logic [WORD_W-1:0] cap_dat_o
);

  logic [WORD_W-1:0] sreg_q;
  logic [WORD_W-1:0] cap_q;

  // Capture is cleared on load so unshifted bits of a short last word read back as zero.
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
      cap_q  <= '0;
    end else if (load_i) begin
      sreg_q <= load_dat_i;
      cap_q  <= '0;
    end else if (shift_i) begin
      sreg_q           <= sreg_q >> 1;
      cap_q[cap_idx_i] <= tail_i;
    end
  end

  assign head_o    = sreg_q[0];
  assign cap_dat_o = cap_q;

endmodule

// File: rtl/ccff_loader.sv
// Serializes bitstream words onto the config chain and returns the tail bits as readback words.
// Per word: 1 fetch + up to WORD_W shift + 1 emit cycles; stalls on in_valid/out_ready freeze the chain.
module ccff_loader import ccff_pkg::*; #(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN,
  parameter int WORD_W    = CCFF_WORD_W
) (
  input  logic          prog_clk,
  input  logic          reset,
  ccff_loader_if.slave  bus
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = idx_w(WORD_W);
  localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);

  ccff_state_t       state_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [IW-1:0]     idx_q;
  logic              shift_en_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;

  logic              load;
  logic              shift;
  logic              last_bit;
  logic              head;
  logic [WORD_W-1:0] cap_dat;

  assign load     = (state_q == ST_FETCH) && bus.in_valid;
  assign shift    = (state_q == ST_SHIFT);
  // A word ends on a full word or on the final chain bit, whichever comes first.
  assign last_bit = (idx_q == IDX_LAST) || (bit_cnt_q == CNT_LAST);

  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      shift_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q   <= ST_FETCH;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        ST_FETCH: begin
          if (bus.in_valid) begin
            state_q    <= ST_SHIFT;
            shift_en_q <= 1'b1;
            idx_q      <= '0;
          end
        end
        ST_SHIFT: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          idx_q     <= idx_q + 1'b1;
          if (last_bit) begin
            state_q     <= ST_EMIT;
            shift_en_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bit_cnt_q == CNT_FULL) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ccff_serdes #(
    .WORD_W (WORD_W),
    .IW     (IW)
  ) u_serdes (
    .prog_clk   (prog_clk),
    .reset      (reset),
    .load_i     (load),
    .load_dat_i (bus.in_data),
    .shift_i    (shift),
    .tail_i     (bus.ccff_tail),
    .cap_idx_i  (idx_q),
    .head_o     (head),
    .cap_dat_o  (cap_dat)
  );

  assign bus.in_ready      = (state_q == ST_FETCH);
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = cap_dat;
  assign bus.ccff_head     = head;
  assign bus.ccff_shift_en = shift_en_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Two loader instances (64-bit and 20-bit chains) driven concurrently against a bit-queue chain reference.
module tb_ccff_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int fin_cnt = 0;

  function automatic void chk(input int cl, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (chain %0d): got %0h, expected %0h", nm, cl, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int CL = (g == 0) ? 64 : 20;
    localparam int W = 8;
    localparam int NW = (CL + W - 1) / W;
    localparam int ABORT_AT = (CL * 15) / 32;
    localparam int TMO = 40 * CL + 400;

    logic rst_n;
    logic [CL-1:0] chain = '0;
    ccff_loader_if #(.WORD_W(W)) bus ();

    ccff_loader #(.CHAIN_LEN(CL), .WORD_W(W)) u_dut (
      .prog_clk (clk),
      .reset    (rst_n),
      .bus      (bus)
    );

    // Fabric chain: head enters at bit 0, tail is the far end.
    assign bus.ccff_tail = chain[CL-1];
    always @(posedge clk) if (bus.ccff_shift_en === 1'b1) chain <= {chain[CL-2:0], bus.ccff_head};

    bit ref_q[$];
    logic [W-1:0] exp_q[$];
    bit stall = 1'b0;
    int shift_cnt, done_cnt, viol_cnt, first_sh_cyc, done_cyc;

    always begin
      @(posedge clk);
      #1;
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
      logic [W-1:0] ew;
      if (bus.ccff_shift_en === 1'b1) begin
        if (shift_cnt == 0) first_sh_cyc = cyc;
        shift_cnt++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) viol_cnt++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL readback_extra (chain %0d): got %0h, expected no word", CL, bus.out_data);
        end else begin
          ew = exp_q.pop_front();
          chk(CL, "readback", 64'(bus.out_data), 64'(ew));
        end
      end
    end

    initial begin
      logic [W-1:0] words [NW];
      logic [W-1:0] saved [NW];
      bit stream [CL];
      logic [W-1:0] ew;
      logic [CL-1:0] exp_chain;
      bit abort, extra, aborted;
      int k, t0, tw, tw2, tw3;

      for (int i = 0; i < CL; i++) ref_q.push_back(1'b0);
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2 chk(CL, "reset_outputs", 64'({bus.in_ready, bus.out_valid, bus.out_data, bus.ccff_head,
                                        bus.ccff_shift_en, bus.busy, bus.done}), 64'(0));
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      for (int sc = 0; sc < 6; sc++) begin
        for (int i = 0; i < NW; i++) begin
          case (sc)
            0: words[i] = (CL == 20) ? W'(8'hAA + 8'h11 * i) : W'(i + 1);
            1: words[i] = 8'hFF;
            2: begin words[i] = W'($urandom); saved[i] = words[i]; end
            3: words[i] = saved[i];
            default: words[i] = W'($urandom);
          endcase
        end
        stall = (sc == 3);
        abort = (sc == 4);
        extra = (sc == 5);
        aborted = 1'b0;
        k = abort ? ABORT_AT : CL;

        // Readback is the chain's previous contents, tail-first; only completed words come back.
        for (int i = 0; i < CL; i++) stream[i] = words[i / W][i % W];
        for (int j = 0; j < (abort ? k / W : NW); j++) begin
          ew = '0;
          for (int b = 0; b < W; b++) if (j * W + b < CL) ew[b] = ref_q[j * W + b];
          exp_q.push_back(ew);
        end
        for (int i = 0; i < k; i++) begin
          void'(ref_q.pop_front());
          ref_q.push_back(stream[i]);
        end

        shift_cnt = 0;
        done_cnt = 0;
        viol_cnt = 0;
        first_sh_cyc = -1;
        done_cyc = -1;
        @(posedge clk);
        #1;
        fork
          begin
            for (int i = 0; i < NW; i++) begin
              if (stall) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
              bus.in_valid = 1'b1;
              bus.in_data = words[i];
              tw = 0;
              do begin @(negedge clk); tw++; end while (bus.in_ready !== 1'b1 && tw < TMO && !aborted);
              @(posedge clk);
              #1 bus.in_valid = 1'b0;
              if (aborted) break;
            end
          end
          begin
            bus.start = 1'b1;
            t0 = cyc;
            @(posedge clk);
            #1 bus.start = 1'b0;
            @(negedge clk) chk(CL, "busy_in_load", 64'(bus.busy), 64'(1));
            tw2 = 0;
            if (abort) begin
              while (shift_cnt < k && tw2 < TMO) begin @(posedge clk); tw2++; end
              #1 rst_n = 1'b0;
              aborted = 1'b1;
              #1 chk(CL, "abort_outputs", 64'({bus.in_ready, bus.out_valid, bus.out_data, bus.ccff_head,
                                                 bus.ccff_shift_en, bus.busy, bus.done}), 64'(0));
              repeat (2) @(posedge clk);
              @(negedge clk) rst_n = 1'b1;
            end else begin
              while (done_cnt == 0 && tw2 < TMO) begin @(posedge clk); tw2++; end
            end
          end
          begin
            if (extra) begin
              tw3 = 0;
              while (shift_cnt < 3 && tw3 < TMO) begin @(posedge clk); tw3++; end
              #1 bus.start = 1'b1;
              @(posedge clk);
              #1 bus.start = 1'b0;
            end
          end
        join

        repeat (3) @(negedge clk);
        for (int i = 0; i < CL; i++) exp_chain[CL-1-i] = ref_q[i];
        chk(CL, "shift_count", 64'(shift_cnt), 64'(k));
        chk(CL, "done_count", 64'(done_cnt), abort ? 64'(0) : 64'(1));
        chk(CL, "stall_shift_en", 64'(viol_cnt), 64'(0));
        chk(CL, "readback_left", 64'(exp_q.size()), 64'(0));
        chk(CL, "chain_contents", 64'(chain), 64'(exp_chain));
        chk(CL, "busy_after", 64'({bus.busy, bus.done}), 64'(0));
        if (!stall && !abort) begin
          chk(CL, "start_to_shift", 64'(first_sh_cyc - t0), 64'(2));
          chk(CL, "start_to_done", 64'(done_cyc - t0), 64'(CL + 2 * NW + 1));
        end
        exp_q.delete();
      end
      fin_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && fin_cnt < 2; t++) @(posedge clk);
    if (fin_cnt < 2) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bench_timeout: finished %0d harnesses, expected 2", fin_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
